// File: rtl/avr_cpu_pkg.sv
// Shared definitions for the AVR call/return control path: FSM encoding and defaults.
package avr_cpu_pkg;

  localparam int unsigned AwDefault = 9;

  localparam logic [AwDefault-1:0] ResetVector = '0;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StPush = 2'd1,
    StPop  = 2'd2,
    StLoad = 2'd3
  } state_e;

endpackage

// File: rtl/avr_cpu_callret_if.sv
// Decoder/fetch-side signal bundle of avr_cpu_callret. Optional irq ports exist only when
// AVR_CALLRET_IRQ_EN is defined.
interface avr_cpu_callret_if #(
  parameter int unsigned AW = 9
);
  logic          call;
  logic          ret;
  logic          clr_err;
  logic [AW-1:0] pc_in;
  logic [AW-1:0] target;
  logic          stack_write;
  logic          stack_read;
  logic [AW-1:0] pc_out;
  logic          pc_load;
  logic          busy;
  logic          overflow;
  logic          underflow;
`ifdef AVR_CALLRET_IRQ_EN
  logic          irq;
  logic [AW-1:0] irq_vector;
  logic          irq_ack;

  modport master (
    output call, ret, clr_err, pc_in, target, irq, irq_vector,
    input  stack_write, stack_read, pc_out, pc_load, busy, overflow, underflow, irq_ack
  );

  modport slave (
    input  call, ret, clr_err, pc_in, target, irq, irq_vector,
    output stack_write, stack_read, pc_out, pc_load, busy, overflow, underflow, irq_ack
  );
`else
  modport master (
    output call, ret, clr_err, pc_in, target,
    input  stack_write, stack_read, pc_out, pc_load, busy, overflow, underflow
  );

  modport slave (
    input  call, ret, clr_err, pc_in, target,
    output stack_write, stack_read, pc_out, pc_load, busy, overflow, underflow
  );
`endif
endinterface

// File: rtl/avr_cpu_stack_depth.sv
// Saturating up/down occupancy counter with full/empty flags; shared with avr_cpu_stack.
module avr_cpu_stack_depth #(
  parameter int unsigned DEPTH = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_inc,
  input  logic i_dec,
  output logic o_full,
  output logic o_empty
);

  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_d;

  always_comb begin
    w_cnt_d = r_cnt;
    if (i_inc && !i_dec && (r_cnt != CW'(DEPTH))) begin
      w_cnt_d = r_cnt + CW'(1);
    end else if (i_dec && !i_inc && (r_cnt != '0)) begin
      w_cnt_d = r_cnt - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_cnt_d;
    end
  end

  assign o_full  = (r_cnt == CW'(DEPTH));
  assign o_empty = (r_cnt == '0);

endmodule

// File: rtl/avr_cpu_callret.sv
// CALL/RET sequencer feeding avr_cpu_stack over a shared tristate bus and loading the fetch PC.
// Optional interrupt entry is enabled with AVR_CALLRET_IRQ_EN.
module avr_cpu_callret
  import avr_cpu_pkg::*;
#(
  parameter int unsigned AW    = AwDefault,
  parameter int unsigned DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  avr_cpu_callret_if.slave          cr_if,
  inout  wire  [AW-1:0]             stack_data
);

  state_e        r_state;
  state_e        w_state_d;

  logic [AW-1:0] r_push_data;
  logic [AW-1:0] w_push_data_d;
  logic [AW-1:0] r_load_val;
  logic [AW-1:0] w_load_val_d;
  logic [AW-1:0] r_pc_out;
  logic [AW-1:0] w_pc_out_d;

  logic          r_stack_write;
  logic          r_stack_read;
  logic          r_pc_load;
  logic          r_busy;
  logic          r_overflow;
  logic          r_underflow;
  logic          r_irq_pend;
  logic          w_irq_pend_d;
  logic          r_irq_ack;

  logic          w_inc;
  logic          w_dec;
  logic          w_full;
  logic          w_empty;
  logic          w_ovf_set;
  logic          w_unf_set;
  logic          w_push_req;
  logic [AW-1:0] w_push_addr;
  logic [AW-1:0] w_jump_addr;

  avr_cpu_stack_depth #(
    .DEPTH (DEPTH)
  ) u_depth (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_inc   (w_inc),
    .i_dec   (w_dec),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // A push request (CALL or IRQ) shares one path: push if room, otherwise flag and jump anyway.
  always_comb begin
    w_push_req   = 1'b0;
    w_push_addr  = cr_if.pc_in + AW'(1);
    w_jump_addr  = cr_if.target;
    w_irq_pend_d = r_irq_pend;
`ifdef AVR_CALLRET_IRQ_EN
    if (cr_if.irq) begin
      w_push_req   = 1'b1;
      w_push_addr  = cr_if.pc_in;
      w_jump_addr  = cr_if.irq_vector;
    end else if (!cr_if.ret && cr_if.call) begin
      w_push_req   = 1'b1;
    end
`else
    if (!cr_if.ret && cr_if.call) begin
      w_push_req   = 1'b1;
    end
`endif
    if (r_state == StIdle) begin
`ifdef AVR_CALLRET_IRQ_EN
      w_irq_pend_d = cr_if.irq;
`else
      w_irq_pend_d = 1'b0;
`endif
    end
  end

  always_comb begin
    w_state_d     = r_state;
    w_push_data_d = r_push_data;
    w_load_val_d  = r_load_val;
    w_inc         = 1'b0;
    w_dec         = 1'b0;
    w_ovf_set     = 1'b0;
    w_unf_set     = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (w_push_req) begin
          w_load_val_d = w_jump_addr;
          if (w_full) begin
            w_ovf_set = 1'b1;
            w_state_d = StLoad;
          end else begin
            w_push_data_d = w_push_addr;
            w_inc         = 1'b1;
            w_state_d     = StPush;
          end
        end else if (cr_if.ret) begin
          if (w_empty) begin
            w_unf_set    = 1'b1;
            w_load_val_d = AW'(ResetVector);
            w_state_d    = StLoad;
          end else begin
            w_dec     = 1'b1;
            w_state_d = StPop;
          end
        end
      end
      StPush:  w_state_d = StLoad;
      StPop:   w_state_d = StLoad;
      StLoad:  w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase

    // The popped return address is on the bus only during POP, so capture it on that edge.
    w_pc_out_d = r_pc_out;
    if (w_state_d == StLoad) begin
      w_pc_out_d = (r_state == StPop) ? stack_data : w_load_val_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= StIdle;
      r_push_data   <= '0;
      r_load_val    <= '0;
      r_pc_out      <= AW'(ResetVector);
      r_stack_write <= 1'b0;
      r_stack_read  <= 1'b0;
      r_pc_load     <= 1'b0;
      r_busy        <= 1'b0;
      r_overflow    <= 1'b0;
      r_underflow   <= 1'b0;
      r_irq_pend    <= 1'b0;
      r_irq_ack     <= 1'b0;
    end else begin
      r_state       <= w_state_d;
      r_push_data   <= w_push_data_d;
      r_load_val    <= w_load_val_d;
      r_pc_out      <= w_pc_out_d;
      r_stack_write <= (w_state_d == StPush);
      r_stack_read  <= (w_state_d == StPop);
      r_pc_load     <= (w_state_d == StLoad);
      r_busy        <= (w_state_d != StIdle);
      r_overflow    <= w_ovf_set | (r_overflow & ~cr_if.clr_err);
      r_underflow   <= w_unf_set | (r_underflow & ~cr_if.clr_err);
      r_irq_pend    <= w_irq_pend_d;
      r_irq_ack     <= (w_state_d == StLoad) & w_irq_pend_d;
    end
  end

  assign stack_data        = r_stack_write ? r_push_data : 'z;

  assign cr_if.stack_write = r_stack_write;
  assign cr_if.stack_read  = r_stack_read;
  assign cr_if.pc_out      = r_pc_out;
  assign cr_if.pc_load     = r_pc_load;
  assign cr_if.busy        = r_busy;
  assign cr_if.overflow    = r_overflow;
  assign cr_if.underflow   = r_underflow;
`ifdef AVR_CALLRET_IRQ_EN
  assign cr_if.irq_ack     = r_irq_ack;
`else
  logic w_unused_irq;
  assign w_unused_irq = r_irq_ack;
`endif

endmodule

// File: tb/tb_avr_cpu_callret.sv
// Scoreboard bench for avr_cpu_callret with a behavioural LIFO stack on the shared bus.
`timescale 1ns/1ps
module tb_avr_cpu_callret;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  wire  [8:0] stack_data;

  int n_checks = 0;
  int n_errors = 0;

  logic [8:0] push_q[$];
  logic [9:0] pc_q[$];   // {irq_ack, pc_out}

  avr_cpu_callret_if #(.AW(9)) ifc ();

  avr_cpu_callret #(
    .AW    (9),
    .DEPTH (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cr_if      (ifc),
    .stack_data (stack_data)
  );

  always #5 clk = ~clk;

  // Behavioural stack: records pushes, drives the top entry during a read cycle.
  logic [8:0] mem [0:7];
  int         sp;
  logic [8:0] w_top;

  always_comb begin
    w_top = '0;
    if (sp > 0) w_top = mem[3'(sp - 1)];
  end

  assign stack_data = ifc.stack_read ? w_top : 'z;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp <= 0;
    end else if (ifc.stack_write) begin
      mem[3'(sp)] <= stack_data;
      sp          <= sp + 1;
    end else if (ifc.stack_read && sp > 0) begin
      sp <= sp - 1;
    end
  end

  logic ack_now;
`ifdef AVR_CALLRET_IRQ_EN
  assign ack_now = ifc.irq_ack;
`else
  assign ack_now = 1'b0;
`endif

  // Monitor: pops expectations whenever the DUT presents a push or a PC load.
  always @(negedge clk) begin
    if (rst_n) begin
      if (ifc.stack_write || ifc.stack_read) begin
        n_checks++;
        if (ifc.stack_write && ifc.stack_read) begin
          n_errors++;
          $display("FAIL strobe_excl: write=%b read=%b, required not both", ifc.stack_write,
                   ifc.stack_read);
        end
      end
      if (ifc.stack_write) begin
        n_checks++;
        if (push_q.size() == 0) begin
          n_errors++;
          $display("FAIL push_unexpected: bus=%h, required no push", stack_data);
        end else begin
          automatic logic [8:0] e = push_q.pop_front();
          if (stack_data !== e) begin
            n_errors++;
            $display("FAIL push_data: got %h, required %h", stack_data, e);
          end
        end
      end
      if (ifc.pc_load || ack_now) begin
        n_checks++;
        if (pc_q.size() == 0) begin
          n_errors++;
          $display("FAIL load_unexpected: pc_load=%b ack=%b pc_out=%h", ifc.pc_load, ack_now,
                   ifc.pc_out);
        end else begin
          automatic logic [9:0] e = pc_q.pop_front();
          if ({ack_now, ifc.pc_out} !== e || !ifc.pc_load) begin
            n_errors++;
            $display("FAIL pc_load: got ack=%b pc=%h load=%b, required ack=%b pc=%h",
                     ack_now, ifc.pc_out, ifc.pc_load, e[9], e[8:0]);
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [8:0] act, input logic [8:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (!ifc.busy) return;
    end
    n_checks++;
    n_errors++;
    $display("FAIL idle_timeout: busy=%b, required 0 within 10 cycles", ifc.busy);
  endtask

  task automatic issue(input logic c, input logic r, input logic q, input logic clr,
                       input logic [8:0] pc, input logic [8:0] tgt);
    ifc.call    = c;
    ifc.ret     = r;
    ifc.clr_err = clr;
    ifc.pc_in   = pc;
    ifc.target  = tgt;
`ifdef AVR_CALLRET_IRQ_EN
    ifc.irq        = q;
    ifc.irq_vector = 9'h002;
`else
    if (q) $display("irq stimulus ignored in this build");
`endif
    @(posedge clk);
    #1;
    ifc.call    = 1'b0;
    ifc.ret     = 1'b0;
    ifc.clr_err = 1'b0;
`ifdef AVR_CALLRET_IRQ_EN
    ifc.irq     = 1'b0;
`endif
    wait_idle();
  endtask

  task automatic do_call(input logic [8:0] pc, input logic [8:0] tgt, input logic full);
    if (!full) push_q.push_back(pc + 9'd1);
    pc_q.push_back({1'b0, tgt});
    issue(1'b1, 1'b0, 1'b0, 1'b0, pc, tgt);
  endtask

  task automatic do_ret(input logic [8:0] exp);
    pc_q.push_back({1'b0, exp});
    issue(1'b0, 1'b1, 1'b0, 1'b0, 9'h000, 9'h000);
  endtask

  task automatic clear_err();
    issue(1'b0, 1'b0, 1'b0, 1'b1, 9'h000, 9'h000);
  endtask

  initial begin
    ifc.call = 0; ifc.ret = 0; ifc.clr_err = 0; ifc.pc_in = '0; ifc.target = '0;
`ifdef AVR_CALLRET_IRQ_EN
    ifc.irq = 0; ifc.irq_vector = '0;
`endif
    repeat (3) @(negedge clk);
    chk("rst_busy", {8'h0, ifc.busy}, 9'h0);
    chk("rst_pc_out", ifc.pc_out, 9'h000);
    chk("rst_strobes", {6'h0, ifc.stack_write, ifc.stack_read, ifc.pc_load}, 9'h0);
    chk("rst_flags", {7'h0, ifc.overflow, ifc.underflow}, 9'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Cycle-accurate CALL: write strobe at +1, PC load at +2.
    push_q.push_back(9'h006);
    pc_q.push_back({1'b0, 9'h040});
    ifc.call = 1'b1; ifc.pc_in = 9'h005; ifc.target = 9'h040;
    @(posedge clk); #1; ifc.call = 1'b0;
    @(negedge clk);
    chk("c1_write", {8'h0, ifc.stack_write}, 9'h1);
    chk("c1_busy", {8'h0, ifc.busy}, 9'h1);
    chk("c1_bus", stack_data, 9'h006);
    @(negedge clk);
    chk("c2_load", {8'h0, ifc.pc_load}, 9'h1);
    chk("c2_pc", ifc.pc_out, 9'h040);
    chk("c2_busy", {8'h0, ifc.busy}, 9'h1);
    @(negedge clk);
    chk("c3_busy", {8'h0, ifc.busy}, 9'h0);
    do_ret(9'h006);

    // LIFO order through a full stack.
    for (int i = 1; i <= 4; i++) do_call(9'(i), 9'(9'h100 + i), 1'b0);
    for (int i = 4; i >= 1; i--) do_ret(9'(i + 1));
    chk("lifo_flags", {7'h0, ifc.overflow, ifc.underflow}, 9'h0);

    // Overflow: fifth CALL jumps without pushing.
    for (int i = 1; i <= 4; i++) do_call(9'(i), 9'h0AA, 1'b0);
    do_call(9'h020, 9'h077, 1'b1);
    chk("ovf_set", {8'h0, ifc.overflow}, 9'h1);
    clear_err();
    chk("ovf_clr", {8'h0, ifc.overflow}, 9'h0);
    for (int i = 4; i >= 1; i--) do_ret(9'(i + 1));

    // Underflow: RET on empty loads reset vector; new error beats clr_err.
    do_ret(9'h000);
    chk("unf_set", {8'h0, ifc.underflow}, 9'h1);
    pc_q.push_back({1'b0, 9'h000});
    issue(1'b0, 1'b1, 1'b0, 1'b1, 9'h000, 9'h000);
    chk("unf_set_wins", {8'h0, ifc.underflow}, 9'h1);
    clear_err();
    chk("unf_clr", {8'h0, ifc.underflow}, 9'h0);

    // Return address wraps.
    do_call(9'h1FF, 9'h003, 1'b0);
    do_ret(9'h000);
    chk("wrap_flags", {7'h0, ifc.overflow, ifc.underflow}, 9'h0);

    // CALL+RET together: RET wins, CALL dropped, stack left empty.
    do_call(9'h030, 9'h050, 1'b0);
    pc_q.push_back({1'b0, 9'h031});
    issue(1'b1, 1'b1, 1'b0, 1'b0, 9'h044, 9'h066);
    do_ret(9'h000);
    chk("both_empty_after", {8'h0, ifc.underflow}, 9'h1);

    // Requests while busy are ignored.
    push_q.push_back(9'h008);
    pc_q.push_back({1'b0, 9'h008});
    ifc.call = 1'b1; ifc.pc_in = 9'h007; ifc.target = 9'h008;
    @(posedge clk); #1; ifc.call = 1'b0; ifc.ret = 1'b1;
    @(posedge clk); @(posedge clk); #1; ifc.ret = 1'b0;
    wait_idle();
    do_ret(9'h008);

    // Async reset mid-PUSH with both sticky flags set.
    for (int i = 1; i <= 4; i++) do_call(9'(i), 9'h0BB, 1'b0);
    do_call(9'h020, 9'h077, 1'b1);
    do_ret(9'h005);
    push_q.push_back(9'h012);
    ifc.call = 1'b1; ifc.pc_in = 9'h011; ifc.target = 9'h022;
    @(posedge clk); #1; ifc.call = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    pc_q.delete();
    #1;
    chk("mid_rst_strobes", {6'h0, ifc.stack_write, ifc.stack_read, ifc.pc_load}, 9'h0);
    chk("mid_rst_busy", {8'h0, ifc.busy}, 9'h0);
    chk("mid_rst_pc", ifc.pc_out, 9'h000);
    chk("mid_rst_flags", {7'h0, ifc.overflow, ifc.underflow}, 9'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_ret(9'h000);
    chk("post_rst_empty", {8'h0, ifc.underflow}, 9'h1);
    clear_err();

`ifdef AVR_CALLRET_IRQ_EN
    push_q.push_back(9'h010);
    pc_q.push_back({1'b1, 9'h002});
    issue(1'b1, 1'b1, 1'b1, 1'b0, 9'h010, 9'h055);
    do_ret(9'h010);
`endif

    repeat (2) @(negedge clk);
    chk("push_q_drained", 9'(push_q.size()), 9'h0);
    chk("pc_q_drained", 9'(pc_q.size()), 9'h0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/avr_cpu_callret.md
Name: avr_cpu_callret

Overview:
- Control stage directly upstream of avr_cpu_stack. Turns CALL / RET requests from the decoder into push and pop transactions on the stack's shared 9-bit tristate data bus.
- Delivers the resulting program-counter load to the fetch stage.
- Tracks stack occupancy and flags overflow and underflow.

Parameters:
- AW, 9, address/data width; must equal the stack data width.
- DEPTH, 4, capacity of avr_cpu_stack in entries; the depth counter saturates here.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- call  in  1  CALL request; sampled only in IDLE.
- ret  in  1  RET request; sampled only in IDLE.
- pc_in  in  AW  address of the current instruction.
- target  in  AW  CALL destination.
- stack_data  inout  AW  shared bus to avr_cpu_stack; driven only in PUSH, otherwise high-Z.
- stack_write  out  1  push strobe to the stack.
- stack_read  out  1  pop strobe to the stack.
- pc_out  out  AW  new PC value.
- pc_load  out  1  one-cycle strobe qualifying pc_out.
- busy  out  1  high in any state other than IDLE.
- overflow  out  1  sticky flag: CALL issued with the stack full.
- underflow  out  1  sticky flag: RET issued with the stack empty.
- clr_err  in  1  synchronous clear of both sticky flags.

Behaviour:
- Reset (asynchronous, any state, including mid-transaction):
  - state=IDLE, depth=0.
  - All strobes 0; pc_out=0; overflow=underflow=0.
  - Bus released (Z).
- FSM states: IDLE, PUSH, POP, LOAD. All outputs are registered.
- IDLE:
  - ret=1 has priority over call. If both are asserted, the CALL is dropped silently.
  - Neither asserted: stay in IDLE, strobes 0.
- CALL with depth<DEPTH:
  - IDLE→PUSH. In PUSH: stack_write=1, bus=(pc_in+1) mod 2^AW, latched at acceptance. depth+1.
  - PUSH→LOAD. In LOAD: pc_out=target (latched at acceptance), pc_load=1.
  - LOAD→IDLE.
  - Total 2 cycles busy; pc_load arrives in the 2nd cycle after acceptance.
- CALL with depth==DEPTH:
  - No PUSH state; go directly IDLE→LOAD. No write strobe.
  - overflow←1. Jump still taken: pc_out=target.
  - depth stays at DEPTH.
- RET with depth>0:
  - IDLE→POP. In POP: stack_read=1, bus released. The stack presents its top entry on the bus during the read cycle. The block captures stack_data at the rising edge that ends POP. depth-1.
  - POP→LOAD. In LOAD: pc_out=captured value, pc_load=1.
  - LOAD→IDLE.
- RET with depth==0:
  - No read strobe. underflow←1.
  - Go to LOAD with pc_out=0 (reset vector).
- Requests arriving while busy=1 are ignored. The decoder must hold or re-issue them.
- Strobe exclusivity: stack_write and stack_read are never high in the same cycle. The bus is never driven by this block while stack_read=1.
- clr_err=1 clears both sticky flags. A new error event in the same cycle wins, so the flag is set.
- Address arithmetic wraps modulo 2^AW: pc_in=9'h1FF gives return address 0.
- Back-to-back operation: a new request is accepted in the cycle after LOAD, so throughput is one CALL/RET per 3 cycles.

Optional Feature:
- Macro: AVR_CALLRET_IRQ_EN.
- When defined:
  - Adds ports irq (in, 1), irq_vector (in, AW), irq_ack (out, 1).
  - irq has priority over ret and call in IDLE.
  - IRQ sequence: pushes pc_in (not pc_in+1) exactly as a CALL would, then loads irq_vector.
  - irq_ack pulses in the LOAD cycle.
  - Full-stack IRQ handling is the same as a full-stack CALL (overflow set, jump taken).
- When undefined: the ports are absent and the priority is ret>call.

Decomposition:
- Shared package avr_cpu_pkg holds:
  - FSM state encoding (IDLE/PUSH/POP/LOAD).
  - Default AW=9.
  - Reset vector constant (0).
- One natural sub-module: avr_cpu_stack_depth, a saturating up/down counter with full/empty outputs, reusable by the stack itself.
- The FSM and bus drive remain in the top module.

Test Plan:
- Reset, then call with pc_in=5, target=9'h40 → cycle+1: stack_write=1, bus=6; cycle+2: pc_load=1, pc_out=9'h40; busy high for both cycles.
- Four CALLs (pc_in=1,2,3,4), then four RETs → pops deliver pc_out=5,4,3,2 in LIFO order; depth returns to 0; no flags set.
- Fifth CALL with depth=4 → no stack_write, overflow=1, pc_out=target. Then clr_err → overflow=0.
- RET at depth 0 → no stack_read, underflow=1, pc_out=0.
- call and ret asserted together at depth 1 → POP path only, depth=0. Also: rst_n low during PUSH → bus Z immediately, all outputs 0, depth 0.
- With AVR_CALLRET_IRQ_EN: irq, ret and call together, pc_in=9'h10, irq_vector=9'h02 → push 9'h10, pc_out=9'h02, irq_ack pulse in the LOAD cycle.
